// File: rtl/register_file_pkg.sv
// Shared sizing constants for the architectural register file.
// ROB id width tracks the ROB depth; register index width tracks NUM_ARCH_REGS.
package register_file_pkg;
  localparam int ROBSIZE       = 4;
  localparam int NUM_ARCH_REGS = 32;
  localparam int REG_IDX_W     = 5;
  localparam int XLEN          = 32;
endpackage

// File: rtl/regfile_read_port.sv
// One operand lookup: state, then same-cycle commit, then ROB value, else wait on tag.
// Purely combinational (zero latency); no backpressure, the caller retries on !rs_ready.
module regfile_read_port
  import register_file_pkg::*;
#(
  parameter int ROB_ID_W = ROBSIZE
) (
  input  logic [REG_IDX_W-1:0] rs_id,
  input  logic [XLEN-1:0]      reg_val,
  input  logic                 reg_busy,
  input  logic [ROB_ID_W-1:0]  reg_tag,
  input  logic                 commit_en,
  input  logic [REG_IDX_W-1:0] commit_rd,
  input  logic [XLEN-1:0]      commit_val,
  input  logic [ROB_ID_W-1:0]  commit_rob_id,
  input  logic                 rob_q_ready,
  input  logic [XLEN-1:0]      rob_q_val,
  output logic                 rs_ready,
  output logic [XLEN-1:0]      rs_val,
  output logic [ROB_ID_W-1:0]  rs_dep
);

  always_comb begin
    rs_ready = 1'b0;
    rs_val   = '0;
    rs_dep   = '0;
    if (rs_id == '0 || !reg_busy) begin
      rs_ready = 1'b1;
      rs_val   = (rs_id == '0) ? '0 : reg_val;
    end else if (commit_en && commit_rd == rs_id && commit_rob_id == reg_tag) begin
      rs_ready = 1'b1;
      rs_val   = commit_val;
    end else if (rob_q_ready) begin
      rs_ready = 1'b1;
      rs_val   = rob_q_val;
    end else begin
      rs_dep   = reg_tag;
    end
  end

endmodule

// File: rtl/register_file.sv
// Architectural register file with per-register rename tag; commit/rename/clear updates on clk.
// Reads are combinational from pre-edge state; rdy low freezes all state (no other backpressure).
module register_file
  import register_file_pkg::*;
#(
  parameter int ROB_ID_W = ROBSIZE,
  parameter int NUM_REGS = NUM_ARCH_REGS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rdy,
  input  logic                 clear,
  input  logic                 commit_en,
  input  logic [REG_IDX_W-1:0] commit_rd,
  input  logic [XLEN-1:0]      commit_val,
  input  logic [ROB_ID_W-1:0]  commit_rob_id,
  input  logic                 dep_en,
  input  logic [REG_IDX_W-1:0] dep_rd,
  input  logic [ROB_ID_W-1:0]  dep_rob_id,
  input  logic [REG_IDX_W-1:0] rs1_id,
  input  logic [REG_IDX_W-1:0] rs2_id,
  output logic [ROB_ID_W-1:0]  rob_qid1,
  output logic [ROB_ID_W-1:0]  rob_qid2,
  input  logic                 rob_q1_ready,
  input  logic                 rob_q2_ready,
  input  logic [XLEN-1:0]      rob_q1_val,
  input  logic [XLEN-1:0]      rob_q2_val,
  output logic                 rs1_ready,
  output logic                 rs2_ready,
  output logic [XLEN-1:0]      rs1_val,
  output logic [XLEN-1:0]      rs2_val,
  output logic [ROB_ID_W-1:0]  rs1_dep,
  output logic [ROB_ID_W-1:0]  rs2_dep
);

  logic [XLEN-1:0]     val_q [NUM_REGS];
  logic [XLEN-1:0]     val_d [NUM_REGS];
  logic [ROB_ID_W-1:0] tag_q [NUM_REGS];
  logic [ROB_ID_W-1:0] tag_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  // Rename is applied after commit so a same-cycle rename of the same rd keeps it busy.
  always_comb begin
    val_d  = val_q;
    tag_d  = tag_q;
    busy_d = busy_q;
    if (rdy) begin
      if (commit_en && commit_rd != '0) begin
        val_d[commit_rd] = commit_val;
        if (tag_q[commit_rd] == commit_rob_id) begin
          busy_d[commit_rd] = 1'b0;
        end
      end
      if (clear) begin
        busy_d = '0;
      end else if (dep_en && dep_rd != '0) begin
        busy_d[dep_rd] = 1'b1;
        tag_d[dep_rd]  = dep_rob_id;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        val_q[i] <= '0;
        tag_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      val_q  <= val_d;
      tag_q  <= tag_d;
      busy_q <= busy_d;
    end
  end

  assign rob_qid1 = tag_q[rs1_id];
  assign rob_qid2 = tag_q[rs2_id];

  regfile_read_port #(.ROB_ID_W(ROB_ID_W)) u_rd1 (
    .rs_id         (rs1_id),
    .reg_val       (val_q[rs1_id]),
    .reg_busy      (busy_q[rs1_id]),
    .reg_tag       (tag_q[rs1_id]),
    .commit_en     (commit_en),
    .commit_rd     (commit_rd),
    .commit_val    (commit_val),
    .commit_rob_id (commit_rob_id),
    .rob_q_ready   (rob_q1_ready),
    .rob_q_val     (rob_q1_val),
    .rs_ready      (rs1_ready),
    .rs_val        (rs1_val),
    .rs_dep        (rs1_dep)
  );

  regfile_read_port #(.ROB_ID_W(ROB_ID_W)) u_rd2 (
    .rs_id         (rs2_id),
    .reg_val       (val_q[rs2_id]),
    .reg_busy      (busy_q[rs2_id]),
    .reg_tag       (tag_q[rs2_id]),
    .commit_en     (commit_en),
    .commit_rd     (commit_rd),
    .commit_val    (commit_val),
    .commit_rob_id (commit_rob_id),
    .rob_q_ready   (rob_q2_ready),
    .rob_q_val     (rob_q2_val),
    .rs_ready      (rs2_ready),
    .rs_val        (rs2_val),
    .rs_dep        (rs2_dep)
  );

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: hand sequences for update corner cases,
// plus a vector table exercising the read-resolution priority with state frozen.
module tb_register_file;

  logic        clk = 1'b0;
  logic        rst_n, rdy, clear;
  logic        commit_en, dep_en;
  logic [4:0]  commit_rd, dep_rd, rs1_id, rs2_id;
  logic [31:0] commit_val, rob_q1_val, rob_q2_val;
  logic [3:0]  commit_rob_id, dep_rob_id;
  logic        rob_q1_ready, rob_q2_ready;
  logic [3:0]  rob_qid1, rob_qid2, rs1_dep, rs2_dep;
  logic        rs1_ready, rs2_ready;
  logic [31:0] rs1_val, rs2_val;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  register_file dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .clear(clear),
    .commit_en(commit_en), .commit_rd(commit_rd), .commit_val(commit_val),
    .commit_rob_id(commit_rob_id),
    .dep_en(dep_en), .dep_rd(dep_rd), .dep_rob_id(dep_rob_id),
    .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rob_qid1(rob_qid1), .rob_qid2(rob_qid2),
    .rob_q1_ready(rob_q1_ready), .rob_q2_ready(rob_q2_ready),
    .rob_q1_val(rob_q1_val), .rob_q2_val(rob_q2_val),
    .rs1_ready(rs1_ready), .rs2_ready(rs2_ready),
    .rs1_val(rs1_val), .rs2_val(rs2_val),
    .rs1_dep(rs1_dep), .rs2_dep(rs2_dep)
  );

  typedef struct {
    logic [4:0]  rs1, rs2;
    logic        ce;
    logic [4:0]  crd;
    logic [3:0]  ctag;
    logic [31:0] cval;
    logic        q1r;
    logic [31:0] q1v;
    logic        q2r;
    logic [31:0] q2v;
    logic        e1r;
    logic [31:0] e1v;
    logic [3:0]  e1d;
    logic        e2r;
    logic [31:0] e2v;
    logic [3:0]  e2d;
    logic [3:0]  eqid1;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clear = 0; commit_en = 0; commit_rd = 0; commit_val = 0; commit_rob_id = 0;
    dep_en = 0; dep_rd = 0; dep_rob_id = 0;
    rob_q1_ready = 0; rob_q1_val = 0; rob_q2_ready = 0; rob_q2_val = 0;
  endtask

  task automatic read1(input string name, input logic [4:0] id,
                       input logic er, input logic [31:0] ev, input logic [3:0] ed);
    rs1_id = id;
    #1;
    check({name, ".ready"}, {31'd0, rs1_ready}, {31'd0, er});
    check({name, ".val"}, rs1_val, ev);
    check({name, ".dep"}, {28'd0, rs1_dep}, {28'd0, ed});
  endtask

  initial begin
    rst_n = 0; rdy = 1; rs1_id = 0; rs2_id = 0;
    idle();
    #12 rst_n = 1;

    // Reset state, then first rename lands one edge later
    read1("reset_x5", 5'd5, 1'b1, 32'h0, 4'd0);
    check("reset_qid1", {28'd0, rob_qid1}, 32'd0);
    dep_en = 1; dep_rd = 5; dep_rob_id = 3;
    #1;
    check("rename_not_visible_same_cycle", {31'd0, rs1_ready}, 32'd1);
    step(); idle();
    read1("renamed_x5", 5'd5, 1'b0, 32'h0, 4'd3);
    check("renamed_x5_qid1", {28'd0, rob_qid1}, 32'd3);

    // Commit forwarding and busy release
    commit_en = 1; commit_rd = 5; commit_rob_id = 3; commit_val = 32'hDEADBEEF;
    read1("commit_fwd_x5", 5'd5, 1'b1, 32'hDEADBEEF, 4'd0);
    step(); idle();
    read1("committed_x5", 5'd5, 1'b1, 32'hDEADBEEF, 4'd0);

    // Older commit must not free a register renamed again
    dep_en = 1; dep_rd = 7; dep_rob_id = 2; step();
    dep_rob_id = 6; step(); idle();
    commit_en = 1; commit_rd = 7; commit_rob_id = 2; commit_val = 32'h11;
    step(); idle();
    read1("stale_commit_x7", 5'd7, 1'b0, 32'h0, 4'd6);
    commit_en = 1; commit_rd = 7; commit_rob_id = 6; commit_val = 32'h22;
    step(); idle();
    read1("young_commit_x7", 5'd7, 1'b1, 32'h22, 4'd0);

    // Same-cycle commit and rename of x4: rename wins
    commit_en = 1; commit_rd = 4; commit_rob_id = 1; commit_val = 32'h44;
    dep_en = 1; dep_rd = 4; dep_rob_id = 5;
    step(); idle();
    read1("rename_wins_x4", 5'd4, 1'b0, 32'h0, 4'd5);
    rob_q1_ready = 1; rob_q1_val = 32'h99;
    read1("robq_fwd_x4", 5'd4, 1'b1, 32'h99, 4'd0);
    idle();

    // Priority table; rdy low so the commits presented here must not change state
    vecs[0] = '{5'd4, 5'd5, 1'b0, 5'd0, 4'd0, 32'h0,  1'b0, 32'h0,  1'b0, 32'h0,
                1'b0, 32'h0,  4'd5, 1'b1, 32'hDEADBEEF, 4'd0, 4'd5};
    vecs[1] = '{5'd4, 5'd7, 1'b1, 5'd4, 4'd5, 32'hAA, 1'b0, 32'h0,  1'b0, 32'h0,
                1'b1, 32'hAA, 4'd0, 1'b1, 32'h22, 4'd0, 4'd5};
    vecs[2] = '{5'd4, 5'd4, 1'b1, 5'd4, 4'd1, 32'hBB, 1'b0, 32'h0,  1'b0, 32'h0,
                1'b0, 32'h0,  4'd5, 1'b0, 32'h0,  4'd5, 4'd5};
    vecs[3] = '{5'd4, 5'd4, 1'b1, 5'd4, 4'd5, 32'hCC, 1'b1, 32'h99, 1'b0, 32'h0,
                1'b1, 32'hCC, 4'd0, 1'b1, 32'hCC, 4'd0, 4'd5};
    vecs[4] = '{5'd0, 5'd0, 1'b1, 5'd0, 4'd0, 32'hFF, 1'b1, 32'h99, 1'b1, 32'h98,
                1'b1, 32'h0,  4'd0, 1'b1, 32'h0,  4'd0, 4'd0};
    vecs[5] = '{5'd7, 5'd4, 1'b0, 5'd0, 4'd0, 32'h0,  1'b0, 32'h0,  1'b1, 32'h1234,
                1'b1, 32'h22, 4'd0, 1'b1, 32'h1234, 4'd0, 4'd6};
    vecs[6] = '{5'd5, 5'd4, 1'b1, 5'd5, 4'd3, 32'h55, 1'b1, 32'h77, 1'b0, 32'h0,
                1'b1, 32'hDEADBEEF, 4'd0, 1'b0, 32'h0, 4'd5, 4'd3};
    rdy = 0;
    for (int i = 0; i < 7; i++) begin
      rs1_id = vecs[i].rs1; rs2_id = vecs[i].rs2;
      commit_en = vecs[i].ce; commit_rd = vecs[i].crd;
      commit_rob_id = vecs[i].ctag; commit_val = vecs[i].cval;
      rob_q1_ready = vecs[i].q1r; rob_q1_val = vecs[i].q1v;
      rob_q2_ready = vecs[i].q2r; rob_q2_val = vecs[i].q2v;
      #2;
      check($sformatf("vec%0d.rs1_ready", i), {31'd0, rs1_ready}, {31'd0, vecs[i].e1r});
      check($sformatf("vec%0d.rs1_val", i), rs1_val, vecs[i].e1v);
      check($sformatf("vec%0d.rs1_dep", i), {28'd0, rs1_dep}, {28'd0, vecs[i].e1d});
      check($sformatf("vec%0d.rs2_ready", i), {31'd0, rs2_ready}, {31'd0, vecs[i].e2r});
      check($sformatf("vec%0d.rs2_val", i), rs2_val, vecs[i].e2v);
      check($sformatf("vec%0d.rs2_dep", i), {28'd0, rs2_dep}, {28'd0, vecs[i].e2d});
      check($sformatf("vec%0d.qid1", i), {28'd0, rob_qid1}, {28'd0, vecs[i].eqid1});
      step();
    end
    idle();
    commit_en = 1; commit_rd = 9; commit_rob_id = 0; commit_val = 32'h5555;
    step(); idle();
    rdy = 1;
    read1("rdy_low_hold_x4", 5'd4, 1'b0, 32'h0, 4'd5);
    read1("rdy_low_no_write_x9", 5'd9, 1'b1, 32'h0, 4'd0);
    read1("rdy_low_keep_x5", 5'd5, 1'b1, 32'hDEADBEEF, 4'd0);

    // Flush: clears all busy, blocks rename, still writes commit value
    dep_en = 1; dep_rd = 1; dep_rob_id = 1; step();
    dep_rd = 2; dep_rob_id = 2; step();
    dep_rd = 3; dep_rob_id = 3; step(); idle();
    clear = 1; dep_en = 1; dep_rd = 9; dep_rob_id = 7;
    commit_en = 1; commit_rd = 2; commit_rob_id = 9; commit_val = 32'h222;
    read1("pre_clear_x1", 5'd1, 1'b0, 32'h0, 4'd1);
    step(); idle();
    read1("clear_x1", 5'd1, 1'b1, 32'h0, 4'd0);
    read1("clear_x2", 5'd2, 1'b1, 32'h222, 4'd0);
    read1("clear_x3", 5'd3, 1'b1, 32'h0, 4'd0);
    read1("clear_x4", 5'd4, 1'b1, 32'h44, 4'd0);
    read1("clear_x9", 5'd9, 1'b1, 32'h0, 4'd0);
    check("clear_x9_qid1", {28'd0, rob_qid1}, 32'd0);

    // x0 is never written or renamed
    commit_en = 1; commit_rd = 0; commit_rob_id = 0; commit_val = 32'hFFFF;
    dep_en = 1; dep_rd = 0; dep_rob_id = 4;
    step(); idle();
    read1("x0", 5'd0, 1'b1, 32'h0, 4'd0);
    check("x0_qid1", {28'd0, rob_qid1}, 32'd0);

    // Asynchronous reset mid-cycle
    dep_en = 1; dep_rd = 6; dep_rob_id = 2; step(); idle();
    commit_en = 1; commit_rd = 8; commit_rob_id = 0; commit_val = 32'h88;
    step(); idle();
    read1("pre_reset_x6", 5'd6, 1'b0, 32'h0, 4'd2);
    read1("pre_reset_x8", 5'd8, 1'b1, 32'h88, 4'd0);
    rst_n = 0;
    read1("async_reset_x6", 5'd6, 1'b1, 32'h0, 4'd0);
    read1("async_reset_x8", 5'd8, 1'b1, 32'h0, 4'd0);
    read1("async_reset_x5", 5'd5, 1'b1, 32'h0, 4'd0);
    step();
    rst_n = 1;
    step();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
